// File: rtl/led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// led_scan_ctrl
//
// Time-multiplexing scan controller for a bank of common-anode 7-segment
// digits that share one led_decoder. It walks the digits one at a time
// (DRIVE slot followed by an all-off DEAD gap), feeds the shared decoder with
// the current digit's nibble/dot/enable, and drives the active-low digit
// selects. Display values are double-buffered: a write lands in a pending
// buffer and is copied into the displayed shadow only at a frame boundary.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   wr_en        one-cycle write strobe
//   wr_data      new hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   wr_dot       new decimal points, 1 = lit
//   lzb_en       leading-zero blanking enable (sampled every cycle)
//   dec_dat      nibble to the shared decoder
//   dec_dot      dot to the shared decoder
//   dec_en       enable to the shared decoder
//   dig_sel_n    active-low digit selects, at most one low
//   frame_sync   one-cycle pulse during the frame-boundary cycle
//   upd_pending  a written value is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module led_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dot,
    input  logic                  lzb_en,
    output logic [3:0]            dec_dat,
    output logic                  dec_dot,
    output logic                  dec_en,
    output logic [DIGITS-1:0]     dig_sel_n,
    output logic                  frame_sync,
    output logic                  upd_pending
);

    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (PRESCALE > DEAD) ? PRESCALE : DEAD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD - 1);

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_DEAD  = 1'b1
    } state_t;

    // Scan state
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Display buffers
    logic [4*DIGITS-1:0]  pend_data_q, pend_data_d;
    logic [DIGITS-1:0]    pend_dot_q, pend_dot_d;
    logic [4*DIGITS-1:0]  shd_data_q, shd_data_d;
    logic [DIGITS-1:0]    shd_dot_q, shd_dot_d;
    logic                 upd_pending_q, upd_pending_d;

    // Registered outputs
    logic [3:0]           dec_dat_q, dec_dat_d;
    logic                 dec_dot_q, dec_dot_d;
    logic                 dec_en_q, dec_en_d;
    logic [DIGITS-1:0]    dig_sel_n_q, dig_sel_n_d;
    logic                 frame_sync_q, frame_sync_d;

    logic                 boundary;
    logic                 blank;

    // Nibble view of the next shadow value, so the outputs registered for the
    // first DRIVE cycle after a boundary already show the new value.
    logic [3:0]           nib [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nib[gi] = shd_data_d[4*gi +: 4];
    end

    // Current cycle is the last DEAD cycle of the last digit.
    assign boundary = (state_q == ST_DEAD) && (cnt_q == DEAD_LAST) && (idx_q == IDX_LAST);

    // Scan sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_DEAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
        endcase
    end

    // Double buffer. A write arriving on the boundary cycle bypasses the
    // pending buffer so it is not shown a frame late behind an older value.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dot_d    = pend_dot_q;
        shd_data_d    = shd_data_q;
        shd_dot_d     = shd_dot_q;
        upd_pending_d = upd_pending_q;
        if (wr_en) begin
            pend_data_d   = wr_data;
            pend_dot_d    = wr_dot;
            upd_pending_d = 1'b1;
        end
        if (boundary) begin
            if (wr_en) begin
                shd_data_d    = wr_data;
                shd_dot_d     = wr_dot;
                upd_pending_d = 1'b0;
            end else if (upd_pending_q) begin
                shd_data_d    = pend_data_q;
                shd_dot_d     = pend_dot_q;
                upd_pending_d = 1'b0;
            end
        end
    end

    // Outputs are computed from the next state so that, once registered, they
    // line up exactly with the state they describe.
    always_comb begin
        // Blanked when every nibble from this digit upward is zero; digit 0
        // always shows.
        blank = lzb_en && (idx_d != '0) && ((shd_data_d >> {idx_d, 2'b00}) == '0);

        dig_sel_n_d  = '1;
        dec_dat_d    = dec_dat_q;
        dec_dot_d    = dec_dot_q;
        dec_en_d     = 1'b0;
        frame_sync_d = (state_d == ST_DEAD) && (cnt_d == DEAD_LAST) && (idx_d == IDX_LAST);
        if (state_d == ST_DRIVE) begin
            dig_sel_n_d[idx_d] = 1'b0;
            dec_dat_d          = nib[idx_d];
            dec_dot_d          = shd_dot_d[idx_d] && !blank;
            dec_en_d           = !blank;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_DEAD;
            idx_q         <= IDX_LAST;
            cnt_q         <= '0;
            pend_data_q   <= '0;
            pend_dot_q    <= '0;
            shd_data_q    <= '0;
            shd_dot_q     <= '0;
            upd_pending_q <= 1'b0;
            dec_dat_q     <= '0;
            dec_dot_q     <= 1'b0;
            dec_en_q      <= 1'b0;
            dig_sel_n_q   <= '1;
            frame_sync_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            pend_data_q   <= pend_data_d;
            pend_dot_q    <= pend_dot_d;
            shd_data_q    <= shd_data_d;
            shd_dot_q     <= shd_dot_d;
            upd_pending_q <= upd_pending_d;
            dec_dat_q     <= dec_dat_d;
            dec_dot_q     <= dec_dot_d;
            dec_en_q      <= dec_en_d;
            dig_sel_n_q   <= dig_sel_n_d;
            frame_sync_q  <= frame_sync_d;
        end
    end

    assign dec_dat     = dec_dat_q;
    assign dec_dot     = dec_dot_q;
    assign dec_en      = dec_en_q;
    assign dig_sel_n   = dig_sel_n_q;
    assign frame_sync  = frame_sync_q;
    assign upd_pending = upd_pending_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_scan_ctrl
//
// Bench for led_scan_ctrl with DIGITS=4, PRESCALE=4, DEAD=2. A reference
// model derives the expected outputs of each cycle from the cycle number since
// reset (position in the frame) and from the writes it sees; the expectation
// is queued at the clock edge and compared against the DUT on the falling
// edge. The selects are also watched every cycle for overlap and missing gaps.
// -----------------------------------------------------------------------------
module tb_led_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 4;
    localparam int D     = 2;
    localparam int SLOT  = P + D;
    localparam int FRAME = N * SLOT;

    logic           clk;
    logic           rst_n;
    logic           wr_en;
    logic [4*N-1:0] wr_data;
    logic [N-1:0]   wr_dot;
    logic           lzb_en;
    logic [3:0]     dec_dat;
    logic           dec_dot;
    logic           dec_en;
    logic [N-1:0]   dig_sel_n;
    logic           frame_sync;
    logic           upd_pending;

    led_scan_ctrl #(
        .DIGITS   (N),
        .PRESCALE (P),
        .DEAD     (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_dot      (wr_dot),
        .lzb_en      (lzb_en),
        .dec_dat     (dec_dat),
        .dec_dot     (dec_dot),
        .dec_en      (dec_en),
        .dig_sel_n   (dig_sel_n),
        .frame_sync  (frame_sync),
        .upd_pending (upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [N-1:0] sel;
        logic [3:0]   dat;
        logic         dot;
        logic         en;
        logic         fs;
        logic         upd;
    } exp_t;

    exp_t q[$];

    // Model state
    int             m_cyc;
    logic [4*N-1:0] m_shd, m_pend;
    logic [N-1:0]   m_shd_dot, m_pend_dot;
    logic           m_flag;
    logic           m_prev_fs;
    logic [3:0]     m_last_dat;
    logic           m_last_dot;
    exp_t           m_e;
    int             m_u, m_w, m_slot;
    logic           m_drive, m_blank;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cyc      = 1;
            m_shd      = '0;
            m_pend     = '0;
            m_shd_dot  = '0;
            m_pend_dot = '0;
            m_flag     = 1'b0;
            m_prev_fs  = 1'b0;
            m_last_dat = '0;
            m_last_dot = 1'b0;
            m_e        = '{sel: '1, dat: 4'h0, dot: 1'b0, en: 1'b0, fs: 1'b0, upd: 1'b0};
        end else begin
            // Buffer update on the edge that ends the previous cycle
            if (m_prev_fs) begin
                if (wr_en) begin
                    m_shd     = wr_data;
                    m_shd_dot = wr_dot;
                    m_flag    = 1'b0;
                end else if (m_flag) begin
                    m_shd     = m_pend;
                    m_shd_dot = m_pend_dot;
                    m_flag    = 1'b0;
                end
            end else if (wr_en) begin
                m_pend     = wr_data;
                m_pend_dot = wr_dot;
                m_flag     = 1'b1;
            end
            m_cyc = m_cyc + 1;
            // Position in the scan: cycles 1..D after reset are the initial gap,
            // then slots of DRIVE(P) + DEAD(D) for digits 0..N-1.
            m_u     = m_cyc - D;
            m_drive = 1'b0;
            m_slot  = 0;
            m_e.fs  = 1'b0;
            if (m_u <= 0) begin
                m_e.fs = (m_u == 0);
            end else begin
                m_w     = m_u - 1;
                m_slot  = (m_w / SLOT) % N;
                m_drive = (m_w % SLOT) < P;
                m_e.fs  = (m_u % FRAME) == 0;
            end
            if (m_drive) begin
                m_blank    = lzb_en && (m_slot != 0) && ((m_shd >> (4 * m_slot)) == '0);
                m_last_dat = 4'((m_shd >> (4 * m_slot)) & 16'hF);
                m_last_dot = m_shd_dot[m_slot] && !m_blank;
                m_e.sel    = ~(N'(1) << m_slot);
                m_e.en     = !m_blank;
            end else begin
                m_e.sel = '1;
                m_e.en  = 1'b0;
            end
            m_e.dat   = m_last_dat;
            m_e.dot   = m_last_dot;
            m_e.upd   = m_flag;
            m_prev_fs = m_e.fs;
        end
        q.push_back(m_e);
    end

    // ---------------- compare + select monitor ----------------
    exp_t         c_e;
    logic [N-1:0] prev_sel = '1;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            c_e = q.pop_front();
            check_val("dig_sel_n",   32'(dig_sel_n),   32'(c_e.sel));
            check_val("dec_dat",     32'(dec_dat),     32'(c_e.dat));
            check_val("dec_dot",     32'(dec_dot),     32'(c_e.dot));
            check_val("dec_en",      32'(dec_en),      32'(c_e.en));
            check_val("frame_sync",  32'(frame_sync),  32'(c_e.fs));
            check_val("upd_pending", 32'(upd_pending), 32'(c_e.upd));
        end
        check_val("sel_onehot", 32'($countones(~dig_sel_n) <= 1), 32'd1);
        check_val("sel_gap", 32'(!((prev_sel != '1) && (dig_sel_n != '1) && (prev_sel != dig_sel_n))), 32'd1);
        prev_sel = dig_sel_n;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_val(input logic [4*N-1:0] d, input logic [N-1:0] dt);
        wr_data = d;
        wr_dot  = dt;
        wr_en   = 1'b1;
        $display("WR   t=%0t data=%h dot=%b lzb=%0b", $time, d, dt, lzb_en);
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_fs();
        int n = 0;
        while (frame_sync !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        check_val("wait_frame_sync", 32'(frame_sync), 32'd1);
    endtask

    task automatic wait_sel(input logic [N-1:0] target);
        int n = 0;
        while (dig_sel_n !== target && n < 100) begin
            step(1);
            n++;
        end
        check_val("wait_sel", 32'(dig_sel_n), 32'(target));
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_dot  = '0;
        lzb_en  = 1'b0;
        step(3);
        rst_n = 1'b1;

        // Free-running scan, no writes
        step(2 * FRAME + 7);

        // Mid-frame write, shown from the next frame
        write_val(16'h1234, 4'b0100);
        step(2 * FRAME);

        // Leading-zero blanking
        lzb_en = 1'b1;
        write_val(16'h00A0, 4'b1111);
        step(2 * FRAME);
        write_val(16'h0000, 4'b0000);
        step(2 * FRAME);
        lzb_en = 1'b0;
        step(FRAME);

        // Boundary-cycle write overrides the pending value
        write_val(16'h1111, 4'b0001);
        step(3);
        wait_fs();
        write_val(16'h2222, 4'b0010);
        check_val("upd_after_boundary_write", 32'(upd_pending), 32'd0);
        step(2 * FRAME);

        // Asynchronous reset in the middle of digit 2 DRIVE
        wait_sel(4'b1011);
        step(1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_dig_sel_n",   32'(dig_sel_n),   32'hF);
        check_val("rst_dec_en",      32'(dec_en),      32'd0);
        check_val("rst_dec_dat",     32'(dec_dat),     32'd0);
        check_val("rst_dec_dot",     32'(dec_dot),     32'd0);
        check_val("rst_frame_sync",  32'(frame_sync),  32'd0);
        check_val("rst_upd_pending", 32'(upd_pending), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2 * FRAME + 3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
